aes_enc_ctrl: RTL and testbench

- Iterative AES-128 encryption engine.
- Sequences one combinational `round` datapath instance through rounds 1–9, then runs a separate final-round path (no MixColumns) for round 10, one round per clock.
- Accepts plaintext and cipher key over a valid/ready handshake and returns ciphertext over a valid/ready handshake.
- Sits between the host/bus interface and the round datapath.

---
 rtl/aes_pkg.sv | 62 ++++++
 rtl/final_round.sv | 21 ++
 rtl/key_gen.sv | 25 ++
 rtl/mix_columns.sv | 25 ++
 rtl/round.sv | 23 ++
 rtl/shift_rows.sv | 20 ++
 rtl/sub_bytes.sv | 17 +
 rtl/aes_enc_ctrl.sv | 115 +++++++++++
 tb/tb_aes_enc_ctrl.sv | 163 ++++++++++++++++
 9 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, sizes and GF(2^8) helpers for the iterative encryption engine.
package aes_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_RND_W = 4;
    localparam int AES_BLK_W = 128;

    localparam logic [AES_RND_W-1:0] AES_LAST_RND = AES_RND_W'(AES_NR);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = gf_xtime(t);
        end
        return p;
    endfunction

    // S-box computed as multiplicative inverse (x^254, so 0 maps to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] base;
        inv  = 8'h01;
        base = x;
        for (int i = 1; i < 8; i++) begin
            base = gf_mul(base, base);
            inv  = gf_mul(inv, base);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [AES_RND_W-1:0] round_num);
        case (round_num)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/final_round.sv
// Last AES round: same as a normal round but without MixColumns.
module final_round
    import aes_pkg::*;
(
    input  logic [AES_RND_W-1:0] round_num,
    input  logic [AES_BLK_W-1:0] data_in,
    input  logic [AES_BLK_W-1:0] key_in,
    output logic [AES_BLK_W-1:0] round_out
);

    logic [AES_BLK_W-1:0] sb_out;
    logic [AES_BLK_W-1:0] sr_out;
    logic [AES_BLK_W-1:0] rk;

    sub_bytes  u_sub_bytes  (.data_in(data_in), .data_out(sb_out));
    shift_rows u_shift_rows (.data_in(sb_out),  .data_out(sr_out));
    key_gen    u_key_gen    (.round_num(round_num), .key_in(key_in), .key_out(rk));

    assign round_out = sr_out ^ rk;

endmodule

// File: rtl/key_gen.sv
// AES-128 key expansion step: derives round key round_num from round key round_num-1.
module key_gen
    import aes_pkg::*;
(
    input  logic [AES_RND_W-1:0] round_num,
    input  logic [AES_BLK_W-1:0] key_in,
    output logic [AES_BLK_W-1:0] key_out
);

    // RotWord/SubWord/Rcon on the last word, then the running XOR chain.
    always_comb begin
        logic [31:0] w3_rot;
        logic [31:0] temp;
        logic [31:0] n0, n1, n2, n3;
        w3_rot = {key_in[23:0], key_in[31:24]};
        temp   = {sbox(w3_rot[31:24]) ^ rcon(round_num), sbox(w3_rot[23:16]),
                  sbox(w3_rot[15:8]), sbox(w3_rot[7:0])};
        n0 = key_in[127:96] ^ temp;
        n1 = key_in[95:64]  ^ n0;
        n2 = key_in[63:32]  ^ n1;
        n3 = key_in[31:0]   ^ n2;
        key_out = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/mix_columns.sv
// MixColumns: each column multiplied by the fixed {02,03,01,01} circulant matrix.
module mix_columns
    import aes_pkg::*;
(
    input  logic [AES_BLK_W-1:0] data_in,
    output logic [AES_BLK_W-1:0] data_out
);

    // Column-wise matrix multiply in GF(2^8).
    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        data_out = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = data_in[AES_BLK_W-1-32*c      -: 8];
            a1 = data_in[AES_BLK_W-1-32*c-8    -: 8];
            a2 = data_in[AES_BLK_W-1-32*c-16   -: 8];
            a3 = data_in[AES_BLK_W-1-32*c-24   -: 8];
            data_out[AES_BLK_W-1-32*c    -: 8] = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
            data_out[AES_BLK_W-1-32*c-8  -: 8] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
            data_out[AES_BLK_W-1-32*c-16 -: 8] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
            data_out[AES_BLK_W-1-32*c-24 -: 8] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
        end
    end

endmodule

// File: rtl/round.sv
// One full AES round (rounds 1-9) plus the matching key expansion step.
module round
    import aes_pkg::*;
(
    input  logic [AES_RND_W-1:0] round_num,
    input  logic [AES_BLK_W-1:0] data_in,
    input  logic [AES_BLK_W-1:0] key_in,
    output logic [AES_BLK_W-1:0] round_out,
    output logic [AES_BLK_W-1:0] key_out
);

    logic [AES_BLK_W-1:0] sb_out;
    logic [AES_BLK_W-1:0] sr_out;
    logic [AES_BLK_W-1:0] mc_out;

    sub_bytes   u_sub_bytes   (.data_in(data_in), .data_out(sb_out));
    shift_rows  u_shift_rows  (.data_in(sb_out),  .data_out(sr_out));
    mix_columns u_mix_columns (.data_in(sr_out),  .data_out(mc_out));
    key_gen     u_key_gen     (.round_num(round_num), .key_in(key_in), .key_out(key_out));

    assign round_out = mc_out ^ key_out;

endmodule

// File: rtl/shift_rows.sv
// ShiftRows: row r rotates left by r bytes; block is column-major, byte 0 in the MSBs.
module shift_rows
    import aes_pkg::*;
(
    input  logic [AES_BLK_W-1:0] data_in,
    output logic [AES_BLK_W-1:0] data_out
);

    // Byte (row r, col c) takes the byte at (row r, col c+r mod 4).
    always_comb begin
        data_out = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                data_out[AES_BLK_W-1-8*(4*c+r) -: 8] =
                    data_in[AES_BLK_W-1-8*(4*((c+r)%4)+r) -: 8];
            end
        end
    end

endmodule

// File: rtl/sub_bytes.sv
// SubBytes: byte-wise S-box substitution over the whole block.
module sub_bytes
    import aes_pkg::*;
(
    input  logic [AES_BLK_W-1:0] data_in,
    output logic [AES_BLK_W-1:0] data_out
);

    // Substitute all sixteen bytes in parallel.
    always_comb begin
        data_out = '0;
        for (int i = 0; i < 16; i++) begin
            data_out[i*8 +: 8] = sbox(data_in[i*8 +: 8]);
        end
    end

endmodule

// File: rtl/aes_enc_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock, handshakes on both sides.
//
// state | meaning
// IDLE  | waiting for a plaintext/key pair, in_ready high
// RUN   | rounds 1..10 in progress, rnd selects the round
// DONE  | ciphertext held on the output until out_ready
module aes_enc_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10,
    parameter int DATA_W     = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] plaintext,
    input  logic [DATA_W-1:0] key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ciphertext,
    output logic              busy
);

    if (NUM_ROUNDS != AES_NR || DATA_W != AES_BLK_W) begin : g_param_check
        $error("aes_enc_ctrl supports only AES-128 (NUM_ROUNDS=10, DATA_W=128)");
    end

    aes_state_e           state_q;
    aes_state_e           state_d;
    logic [AES_BLK_W-1:0] st_reg;
    logic [AES_BLK_W-1:0] key_reg;
    logic [AES_RND_W-1:0] rnd;

    logic                 accept;
    logic                 step;
    logic                 last;
    logic [AES_BLK_W-1:0] round_out;
    logic [AES_BLK_W-1:0] key_out;
    logic [AES_BLK_W-1:0] final_out;

    round u_round (
        .round_num (rnd),
        .data_in   (st_reg),
        .key_in    (key_reg),
        .round_out (round_out),
        .key_out   (key_out)
    );

    final_round u_final_round (
        .round_num (AES_LAST_RND),
        .data_in   (st_reg),
        .key_in    (key_reg),
        .round_out (final_out)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode and datapath load strobes.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (rnd == AES_LAST_RND) begin
                    last    = 1'b1;
                    state_d = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Cipher state, round key and round counter; round 0 AddRoundKey folds into the load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_reg  <= '0;
            key_reg <= '0;
            rnd     <= '0;
        end else if (accept) begin
            st_reg  <= plaintext ^ key;
            key_reg <= key;
            rnd     <= AES_RND_W'(1);
        end else if (step) begin
            st_reg  <= round_out;
            key_reg <= key_out;
            rnd     <= rnd + AES_RND_W'(1);
        end else if (last) begin
            st_reg  <= final_out;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign ciphertext = st_reg;

endmodule

// File: tb/tb_aes_enc_ctrl.sv
// Directed bench for aes_enc_ctrl using FIPS-197 known-answer vectors.
module tb_aes_enc_ctrl;

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    aes_enc_ctrl #(.NUM_ROUNDS(10), .DATA_W(128)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Count edges until out_valid is seen, bounded so a stuck DUT still reaches the summary.
    task automatic wait_out(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int   lat;
        logic ok_ct, ok_ov, ok_ir, saw_ov;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        plaintext = '0;
        key       = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_in_ready",   128'(in_ready),   128'd1);
        check("rst_busy",       128'(busy),       128'd0);
        check("rst_out_valid",  128'(out_valid),  128'd0);
        check("rst_ciphertext", ciphertext,       128'd0);

        // App. B job, with App. C.1 offered continuously behind it.
        plaintext = PT_B;
        key       = KEY_B;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        plaintext = PT_C;
        key       = KEY_C;
        check("b_busy_after_accept",     128'(busy),     128'd1);
        check("b_in_ready_after_accept", 128'(in_ready), 128'd0);
        wait_out(lat);
        check("b_latency",    128'(lat), 128'd10);
        check("b_ciphertext", ciphertext, CT_B);
        tick();
        check("b_handshake_out_valid", 128'(out_valid), 128'd0);
        check("b_handshake_in_ready",  128'(in_ready),  128'd1);
        check("c_not_yet_busy",        128'(busy),      128'd0);
        tick();
        check("c_accept_busy", 128'(busy), 128'd1);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // App. C.1 result, then 20 cycles of backpressure.
        wait_out(lat);
        check("c_latency",    128'(lat), 128'd10);
        check("c_ciphertext", ciphertext, CT_C);
        ok_ct = 1'b1;
        ok_ov = 1'b1;
        ok_ir = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ciphertext !== CT_C) ok_ct = 1'b0;
            if (out_valid !== 1'b1)  ok_ov = 1'b0;
            if (in_ready !== 1'b0)   ok_ir = 1'b0;
        end
        check("bp_ciphertext_stable", 128'(ok_ct), 128'd1);
        check("bp_out_valid_held",    128'(ok_ov), 128'd1);
        check("bp_in_ready_low",      128'(ok_ir), 128'd1);
        out_ready = 1'b1;
        tick();
        check("bp_release_out_valid", 128'(out_valid), 128'd0);
        check("bp_release_in_ready",  128'(in_ready),  128'd1);

        // Mid-job reset at round 5.
        plaintext = PT_B;
        key       = KEY_B;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",   128'(in_ready),  128'd1);
        check("mid_rst_busy",       128'(busy),      128'd0);
        check("mid_rst_out_valid",  128'(out_valid), 128'd0);
        check("mid_rst_ciphertext", ciphertext,      128'd0);
        tick();
        tick();
        rst_n  = 1'b1;
        saw_ov = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid !== 1'b0) saw_ov = 1'b1;
        end
        check("mid_rst_no_output", 128'(saw_ov), 128'd0);

        // Fresh job after the reset.
        plaintext = PT_C;
        key       = KEY_C;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out(lat);
        check("post_rst_latency",    128'(lat), 128'd10);
        check("post_rst_ciphertext", ciphertext, CT_C);
        tick();
        check("post_rst_idle", 128'(in_ready), 128'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
